// File: rtl/bus_txn_scheduler_if.sv
// rtl/bus_txn_scheduler_if.sv - cache-side and Sysbus-side handshake bundle for bus_txn_scheduler
//  ic_*  : I-cache request/response handshake (reqcyc, req, reqtag, reqack, respcyc, respack)
//  dc_*  : D-cache request/response handshake (same set)
//  bus_* : Sysbus request/response handshake (reqcyc, req, reqtag, reqack, respcyc, respack, resptag)
//  modport master : the scheduler (drives bus_req* toward Sysbus, acks/responses toward caches)
//  modport slave  : the environment (caches plus Sysbus)
interface bus_txn_scheduler_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic                      ic_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] ic_req;
    logic [BUS_TAG_WIDTH-1:0]  ic_reqtag;
    logic                      ic_reqack;
    logic                      ic_respcyc;
    logic                      ic_respack;

    logic                      dc_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] dc_req;
    logic [BUS_TAG_WIDTH-1:0]  dc_reqtag;
    logic                      dc_reqack;
    logic                      dc_respcyc;
    logic                      dc_respack;

    logic                      bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic                      bus_respack;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

    modport master (
        input  ic_reqcyc, ic_req, ic_reqtag, ic_respack,
        output ic_reqack, ic_respcyc,
        input  dc_reqcyc, dc_req, dc_reqtag, dc_respack,
        output dc_reqack, dc_respcyc,
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resptag
    );

    modport slave (
        output ic_reqcyc, ic_req, ic_reqtag, ic_respack,
        input  ic_reqack, ic_respcyc,
        output dc_reqcyc, dc_req, dc_reqtag, dc_respack,
        input  dc_reqack, dc_respcyc,
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resptag
    );
endinterface

// File: rtl/bus_txn_scheduler.sv
// rtl/bus_txn_scheduler.sv - round-robin whole-transaction sharing of the Sysbus port between I-cache and D-cache
//  clk       : clock, all state on posedge
//  reset     : synchronous active-low reset
//  bif       : bus_txn_scheduler_if.master (ic_*, dc_*, bus_* handshakes)
//  sched_err : one-cycle pulse on read-response timeout
//  Optional feature macro: SCHED_TIMEOUT_EN (read-response idle timeout; sched_err tied 0 without it)
module bus_txn_scheduler #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8,
    parameter int TIMEOUT        = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_txn_scheduler_if.master   bif,
    output logic                  sched_err
);
    localparam int CW = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_RRESP
    } state_t;

    state_t                   state, state_nx;
    logic                     owner_dc, owner_dc_nx;
    logic                     last_dc, last_dc_nx;
    logic [CW-1:0]            beat_cnt, beat_cnt_nx;
    logic [BUS_TAG_WIDTH-1:0] tag_q, tag_nx;

    logic                      own_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] own_req;
    logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
    logic                      own_respack;
    logic                      resp_valid;
    logic                      resp_beat;
    logic                      last_beat;

    assign own_reqcyc  = owner_dc ? bif.dc_reqcyc  : bif.ic_reqcyc;
    assign own_req     = owner_dc ? bif.dc_req     : bif.ic_req;
    assign own_reqtag  = owner_dc ? bif.dc_reqtag  : bif.ic_reqtag;
    assign own_respack = owner_dc ? bif.dc_respack : bif.ic_respack;

    // Responses carrying a foreign tag belong to nobody here and are ignored.
    assign resp_valid = bif.bus_respcyc && (bif.bus_resptag == tag_q);
    assign resp_beat  = (state == ST_RRESP) && resp_valid && own_respack;
    assign last_beat  = (beat_cnt == CW'(BEATS - 1));

`ifdef SCHED_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT + 1);
    logic [TOW-1:0] idle_cnt;
    logic           timeout_hit;

    assign timeout_hit = (state == ST_RRESP) && !resp_beat && (idle_cnt == TOW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_cnt  <= '0;
            sched_err <= 1'b0;
        end else begin
            sched_err <= timeout_hit;
            if (state != ST_RRESP || resp_beat) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`else
    assign sched_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            owner_dc <= 1'b0;
            last_dc  <= 1'b0;
            beat_cnt <= '0;
            tag_q    <= '0;
        end else begin
            state    <= state_nx;
            owner_dc <= owner_dc_nx;
            last_dc  <= last_dc_nx;
            beat_cnt <= beat_cnt_nx;
            tag_q    <= tag_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        owner_dc_nx     = owner_dc;
        last_dc_nx      = last_dc;
        beat_cnt_nx     = beat_cnt;
        tag_nx          = tag_q;
        bif.bus_reqcyc  = 1'b0;
        bif.bus_req     = '0;
        bif.bus_reqtag  = '0;
        bif.bus_respack = 1'b0;
        bif.ic_reqack   = 1'b0;
        bif.dc_reqack   = 1'b0;
        bif.ic_respcyc  = 1'b0;
        bif.dc_respcyc  = 1'b0;

        case (state)
            ST_IDLE: begin
                // Grant is registered; on contention the master that did not win last time goes next.
                if (bif.ic_reqcyc || bif.dc_reqcyc) begin
                    owner_dc_nx = (bif.ic_reqcyc && bif.dc_reqcyc) ? !last_dc : bif.dc_reqcyc;
                    last_dc_nx  = owner_dc_nx;
                    state_nx    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                bif.bus_reqcyc = own_reqcyc;
                bif.bus_req    = own_req;
                bif.bus_reqtag = own_reqtag;
                bif.ic_reqack  = !owner_dc && bif.bus_reqack;
                bif.dc_reqack  = owner_dc && bif.bus_reqack;
                if (!own_reqcyc) begin
                    state_nx = ST_IDLE;
                end else if (bif.bus_reqack) begin
                    tag_nx      = own_reqtag;
                    beat_cnt_nx = '0;
                    state_nx    = own_reqtag[BUS_TAG_WIDTH-1] ? ST_RRESP : ST_WDATA;
                end
            end
            ST_WDATA: begin
                bif.bus_reqcyc = own_reqcyc;
                bif.bus_req    = own_req;
                bif.bus_reqtag = own_reqtag;
                bif.ic_reqack  = !owner_dc && bif.bus_reqack;
                bif.dc_reqack  = owner_dc && bif.bus_reqack;
                if (own_reqcyc && bif.bus_reqack) begin
                    beat_cnt_nx = beat_cnt + 1'b1;
                    if (last_beat) begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_RRESP: begin
                bif.ic_respcyc  = !owner_dc && resp_valid;
                bif.dc_respcyc  = owner_dc && resp_valid;
                bif.bus_respack = resp_valid && own_respack;
                if (resp_beat) begin
                    beat_cnt_nx = beat_cnt + 1'b1;
                    if (last_beat) begin
                        state_nx = ST_IDLE;
                    end
                end
`ifdef SCHED_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_nx = ST_IDLE;
                end
`endif
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_bus_txn_scheduler.sv
// tb/tb_bus_txn_scheduler.sv - randomized self-checking bench for bus_txn_scheduler
module tb_bus_txn_scheduler;
    localparam int DW = 64;
    localparam int TW = 13;
    localparam int NB = 8;
`ifdef SCHED_TIMEOUT_EN
    localparam int TMO = 15;
`else
    localparam int TMO = 1023;
`endif

    localparam int P_FREE  = 0;
    localparam int P_ADDR  = 1;
    localparam int P_WRITE = 2;
    localparam int P_READ  = 3;

    logic clk = 1'b0;
    logic reset;
    logic sched_err;

    always #5 clk = ~clk;

    bus_txn_scheduler_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bif();

    bus_txn_scheduler #(
        .BUS_DATA_WIDTH(DW),
        .BUS_TAG_WIDTH (TW),
        .BEATS         (NB),
        .TIMEOUT       (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bif      (bif),
        .sched_err(sched_err)
    );

    typedef struct packed {
        logic                   rd;
        logic [TW-1:0]          tag;
        logic [DW-1:0]          addr;
        logic [NB-1:0][DW-1:0]  data;
    } txn_t;

    int checks = 0;
    int failures = 0;

    // cache agents
    txn_t aq0[$];
    txn_t aq1[$];
    txn_t acur[2];
    int   aphase[2];
    int   abeat[2];
    int   adone[2];
    int   aborted[2];
    int   gen[2];
    int   rsp_hit[2];
    int   own_log[$];
    // sysbus environment
    int            sb_wleft;
    logic [TW-1:0] job_tag[$];
    int            job_left[$];
    bit            mute;
    bit            hold_reset;
    // reference model
    int            m_ph;
    bit            m_own;
    bit            m_last;
    int            m_left;
    logic [TW-1:0] m_tag;
    int            m_idle;
    bit            m_err;
    // observation counters
    int cyc;
    int err_pulses;
    int bus_beats;
    int bra_seen;
    bit lat_arm;
    int lat_req;
    int lat_grant;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk_txn(input bit rd);
        txn_t t;
        t.rd   = rd;
        t.tag  = {rd, 12'($urandom)};
        t.addr = {$urandom, $urandom};
        for (int i = 0; i < NB; i++) t.data[i] = {$urandom, $urandom};
        return t;
    endfunction

    function automatic logic [127:0] outs();
        return {44'd0, bif.bus_reqcyc, bif.bus_req, bif.bus_reqtag, bif.ic_reqack, bif.dc_reqack,
                bif.ic_respcyc, bif.dc_respcyc, bif.bus_respack, sched_err};
    endfunction

    task automatic abort_env(input int m);
        if (aphase[m] != 0) aborted[m]++;
        aphase[m] = 0;
        if (job_tag.size() > 0) begin
            void'(job_tag.pop_front());
            void'(job_left.pop_front());
        end
    endtask

    task automatic step();
        logic          rq[2];
        logic [DW-1:0] rqd[2];
        logic [TW-1:0] rqt[2];
        logic          rk[2];
        logic          e_ack[2];
        logic          e_rsp[2];
        logic          e_bcyc;
        logic          e_bra;
        logic [DW-1:0] e_breq;
        logic [TW-1:0] e_btag;
        logic          acked;
        logic          rsp;
        bit            valid;
        bit            wrong;

        @(negedge clk);
        if (aphase[0] == 0 && aq0.size() > 0) begin acur[0] = aq0.pop_front(); aphase[0] = 1; abeat[0] = 0; end
        if (aphase[1] == 0 && aq1.size() > 0) begin acur[1] = aq1.pop_front(); aphase[1] = 1; abeat[1] = 0; end
        for (int m = 0; m < 2; m++) begin
            rq[m]  = !hold_reset && (aphase[m] == 1 || aphase[m] == 2);
            rqd[m] = (aphase[m] == 2) ? acur[m].data[abeat[m]] : acur[m].addr;
            rqt[m] = acur[m].tag;
            rk[m]  = ($urandom % 4) != 0;
        end
        bif.ic_reqcyc  = rq[0]; bif.ic_req = rqd[0]; bif.ic_reqtag = rqt[0]; bif.ic_respack = rk[0];
        bif.dc_reqcyc  = rq[1]; bif.dc_req = rqd[1]; bif.dc_reqtag = rqt[1]; bif.dc_respack = rk[1];
        bif.bus_reqack = ($urandom % 4) != 0;
        wrong = 0;
        if (!hold_reset && !mute && job_tag.size() > 0 && ($urandom % 10) < 6) begin
            wrong           = ($urandom % 5) == 0;
            bif.bus_respcyc = 1'b1;
            bif.bus_resptag = wrong ? (job_tag[0] ^ 13'h1) : job_tag[0];
        end else begin
            bif.bus_respcyc = 1'b0;
            bif.bus_resptag = 13'($urandom);
        end
        reset = !hold_reset;
        #1;

        // expected outputs from the owner/phase view of the scheduler
        e_bcyc = 0; e_bra = 0; e_breq = '0; e_btag = '0;
        e_ack = '{1'b0, 1'b0};
        e_rsp = '{1'b0, 1'b0};
        valid = bif.bus_respcyc && (bif.bus_resptag == m_tag);
        if (m_ph == P_ADDR || m_ph == P_WRITE) begin
            e_bcyc = rq[m_own]; e_breq = rqd[m_own]; e_btag = rqt[m_own];
            e_ack[m_own] = bif.bus_reqack;
        end else if (m_ph == P_READ) begin
            e_rsp[m_own] = valid;
            e_bra = valid && rk[m_own];
        end
        check("cycle", outs(), {44'd0, e_bcyc, e_breq, e_btag, e_ack[0], e_ack[1], e_rsp[0], e_rsp[1], e_bra, m_err});

        if (lat_arm && (rq[0] || rq[1]) && lat_req < 0) lat_req = cyc;
        if (lat_arm && bif.bus_reqcyc && lat_grant < 0) lat_grant = cyc;
        if (bif.bus_reqcyc && bif.bus_reqack) bus_beats++;
        if (bif.bus_respack) bra_seen++;
        if (sched_err) err_pulses++;

        // sysbus environment reaction
        if (bif.bus_reqcyc && bif.bus_reqack) begin
            if (sb_wleft == 0) begin
                if (bif.bus_reqtag[TW-1]) begin job_tag.push_back(bif.bus_reqtag); job_left.push_back(NB); end
                else sb_wleft = NB;
            end else begin
                sb_wleft--;
            end
        end
        if (bif.bus_respcyc && !wrong && bif.bus_respack && job_left.size() > 0) begin
            job_left[0] = job_left[0] - 1;
            if (job_left[0] == 0) begin void'(job_tag.pop_front()); void'(job_left.pop_front()); end
        end

        // cache agents reaction
        for (int m = 0; m < 2; m++) begin
            acked = (m == 1) ? bif.dc_reqack : bif.ic_reqack;
            rsp   = (m == 1) ? bif.dc_respcyc : bif.ic_respcyc;
            if (rq[m] && acked) begin
                if (aphase[m] == 1) begin
                    own_log.push_back(m);
                    abeat[m]  = 0;
                    aphase[m] = acur[m].rd ? 3 : 2;
                end else begin
                    abeat[m]++;
                    if (abeat[m] == NB) begin aphase[m] = 0; adone[m]++; end
                end
            end
            if (aphase[m] == 3 && rsp && rk[m]) begin
                abeat[m]++;
                rsp_hit[m]++;
                if (abeat[m] == NB) begin aphase[m] = 0; adone[m]++; end
            end
        end

        // reference model advances on the coming edge
        if (hold_reset) begin
            m_ph = P_FREE; m_last = 0; m_err = 0; m_idle = 0;
            aphase[0] = 0; aphase[1] = 0;
            job_tag.delete(); job_left.delete(); sb_wleft = 0;
        end else begin
            m_err = 0;
            case (m_ph)
                P_FREE: if (rq[0] || rq[1]) begin
                    m_own  = (rq[0] && rq[1]) ? !m_last : rq[1];
                    m_last = m_own;
                    m_ph   = P_ADDR;
                end
                P_ADDR: if (!rq[m_own]) begin
                    m_ph = P_FREE;
                end else if (bif.bus_reqack) begin
                    m_tag  = rqt[m_own];
                    m_left = NB;
                    m_idle = 0;
                    m_ph   = rqt[m_own][TW-1] ? P_READ : P_WRITE;
                end
                P_WRITE: if (rq[m_own] && bif.bus_reqack) begin
                    m_left--;
                    if (m_left == 0) m_ph = P_FREE;
                end
                P_READ: if (valid && rk[m_own]) begin
                    m_left--;
                    m_idle = 0;
                    if (m_left == 0) m_ph = P_FREE;
                end
`ifdef SCHED_TIMEOUT_EN
                else begin
                    m_idle++;
                    if (m_idle == TMO) begin
                        m_err = 1;
                        m_ph  = P_FREE;
                        abort_env(int'(m_own));
                    end
                end
`endif
                default: m_ph = P_FREE;
            endcase
        end
        cyc++;
    endtask

    task automatic run_until_quiet(input int budget, input string tag);
        bit quiet;
        quiet = 0;
        for (int i = 0; i < budget && !quiet; i++) begin
            step();
            quiet = aq0.size() == 0 && aq1.size() == 0 && aphase[0] == 0 && aphase[1] == 0 && m_ph == P_FREE;
        end
        check(tag, quiet, 1);
    endtask

    task automatic do_reset();
        hold_reset = 1;
        step();
        step();
        hold_reset = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit hit;
        for (int m = 0; m < 2; m++) begin
            acur[m] = '0; aphase[m] = 0; abeat[m] = 0; adone[m] = 0;
            aborted[m] = 0; gen[m] = 0; rsp_hit[m] = 0;
        end
        sb_wleft = 0; mute = 0; m_ph = P_FREE; m_own = 0; m_last = 0; m_left = 0;
        m_tag = '0; m_idle = 0; m_err = 0; cyc = 0; err_pulses = 0; bus_beats = 0;
        bra_seen = 0; lat_arm = 0; lat_req = -1; lat_grant = -1;

        do_reset();
        check("reset_outs", outs(), 0);

        // I-cache read alone
        lat_arm = 1;
        rsp_hit = '{0, 0};
        own_log.delete();
        aq0.push_back(mk_txn(1));
        run_until_quiet(300, "ic_rd_done");
        lat_arm = 0;
        check("grant_latency", lat_grant - lat_req, 1);
        check("ic_rd_grants", own_log.size(), 1);
        check("ic_rd_owner", own_log[0], 0);
        check("ic_rd_beats", rsp_hit[0], NB);
        check("ic_rd_dc_resp", rsp_hit[1], 0);

        // both request in the same cycle right after reset: D-cache first
        do_reset();
        own_log.delete();
        aq0.push_back(mk_txn(1));
        aq1.push_back(mk_txn(1));
        run_until_quiet(600, "rr_done");
        check("rr_grants", own_log.size(), 2);
        check("rr_first", own_log[0], 1);
        check("rr_second", own_log[1], 0);

        // D-cache write
        own_log.delete();
        bus_beats = 0; bra_seen = 0; adone = '{0, 0};
        aq1.push_back(mk_txn(0));
        run_until_quiet(300, "dc_wr_done");
        check("dc_wr_beats", bus_beats, NB + 1);
        check("dc_wr_respack", bra_seen, 0);
        check("dc_wr_done_cnt", adone[1], 1);

        // reset during read response beat 3, then a fresh read
        rsp_hit = '{0, 0};
        aq0.push_back(mk_txn(1));
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            step();
            hit = aphase[0] == 3 && abeat[0] == 3;
        end
        check("reach_beat3", hit, 1);
        hold_reset = 1;
        step();
        hold_reset = 0;
        @(posedge clk);
        #1;
        check("mid_reset_outs", outs(), 0);
        rsp_hit = '{0, 0};
        aq0.push_back(mk_txn(1));
        run_until_quiet(300, "restart_done");
        check("restart_beats", rsp_hit[0], NB);

`ifdef SCHED_TIMEOUT_EN
        // read with no response at all while the D-cache waits
        do_reset();
        mute = 1;
        err_pulses = 0;
        own_log.delete();
        aq0.push_back(mk_txn(1));
        step();
        step();
        aq1.push_back(mk_txn(0));
        run_until_quiet(300, "tmo_done");
        mute = 0;
        check("tmo_pulses", err_pulses, 1);
        check("tmo_grants", own_log.size(), 2);
        check("tmo_then_dc", own_log[1], 1);
`endif

        // randomized mixed traffic
        gen = '{0, 0}; adone = '{0, 0}; aborted = '{0, 0};
        for (int i = 0; i < 3000; i++) begin
            if (aq0.size() < 2 && ($urandom % 8) == 0) begin aq0.push_back(mk_txn(1'($urandom))); gen[0]++; end
            if (aq1.size() < 2 && ($urandom % 8) == 0) begin aq1.push_back(mk_txn(1'($urandom))); gen[1]++; end
            step();
        end
        run_until_quiet(1000, "rand_drain");
        check("rand_ic_total", adone[0] + aborted[0], gen[0]);
        check("rand_dc_total", adone[1] + aborted[1], gen[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
